// File: rtl/parallax_pkg.sv
// Constants and types shared by the stereo parallax and disparity projection blocks.
package parallax_pkg;

   localparam int unsigned DEPTH_W         = 8;
   localparam int unsigned X_W             = 11;
   localparam int unsigned Y_W             = 10;
   localparam int unsigned NUM_SLOTS       = 4;
   localparam int unsigned DISPARITY_K_DEF = 2973;

   localparam logic [1:0] ONE_PLAYER    = 2'd0;
   localparam logic [1:0] TWO_PLAYERS   = 2'd1;
   localparam logic [1:0] THREE_PLAYERS = 2'd2;
   localparam logic [1:0] FOUR_PLAYERS  = 2'd3;

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StDivide,
      StWrite,
      StDone
   } proj_state_t;

endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per cycle (MSB first) after a start pulse.
module seq_divider #(
   parameter int unsigned DIV_BITS = 12
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_start,
   input  logic [DIV_BITS-1:0] i_dividend,
   input  logic [DIV_BITS-1:0] i_divisor,
   output logic                o_done,
   output logic [DIV_BITS-1:0] o_quotient
);

   localparam int unsigned CNT_W = $clog2(DIV_BITS + 1);

   logic [DIV_BITS-1:0] r_quo;
   logic [DIV_BITS-1:0] r_div;
   logic [DIV_BITS-1:0] r_rem;
   logic [CNT_W-1:0]    r_count;

   logic [DIV_BITS:0]   w_shift;
   logic                w_fits;
   logic [DIV_BITS-1:0] w_rem_next;

   // Dividend bits shift out of r_quo while quotient bits shift in from the bottom.
   always_comb begin
      w_shift    = {r_rem, r_quo[DIV_BITS-1]};
      w_fits     = (w_shift >= {1'b0, r_div});
      w_rem_next = w_fits ? DIV_BITS'(w_shift - {1'b0, r_div}) : w_shift[DIV_BITS-1:0];
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_quo   <= '0;
         r_div   <= '0;
         r_rem   <= '0;
         r_count <= '0;
      end else if (i_start) begin
         r_quo   <= i_dividend;
         r_div   <= i_divisor;
         r_rem   <= '0;
         r_count <= CNT_W'(DIV_BITS);
      end else if (r_count != '0) begin
         r_rem   <= w_rem_next;
         r_quo   <= {r_quo[DIV_BITS-2:0], w_fits};
         r_count <= r_count - 1'b1;
      end
   end

   // High during the final iteration; the quotient is complete after this edge.
   assign o_done     = (r_count == CNT_W'(1));
   assign o_quotient = r_quo;

endmodule

// File: rtl/disparity_projector.sv
// Projects per-player target depth to a camera-2 column (x_2 = x_1 - K/depth).
// Define PROJECTOR_ROUND_EN for round-to-nearest disparity instead of floor.
module disparity_projector
   import parallax_pkg::*;
#(
   parameter int unsigned DISPARITY_K = DISPARITY_K_DEF,
   parameter int unsigned DIV_BITS    = 12
) (
   input  logic                              clk_in,
   input  logic                              rst_n_in,
   input  logic                              data_valid_in,
   input  logic [1:0]                        num_players,
   input  logic [NUM_SLOTS-1:0][DEPTH_W-1:0] depth_in,
   input  logic [NUM_SLOTS-1:0][X_W-1:0]     x_1_in,
   output logic                              busy_out,
   output logic                              data_valid_out,
   output logic [NUM_SLOTS-1:0][X_W-1:0]     x_2_out,
   output logic [NUM_SLOTS-1:0]              clip_out
);

   localparam logic [X_W-1:0] X_MAX = '1;

   proj_state_t                       r_state;
   logic [1:0]                        r_idx;
   logic [1:0]                        r_last;
   logic [NUM_SLOTS-1:0][DEPTH_W-1:0] r_depth;
   logic [NUM_SLOTS-1:0][X_W-1:0]     r_x1;
   logic [NUM_SLOTS-1:0][X_W-1:0]     r_slot_x2;
   logic [NUM_SLOTS-1:0]              r_slot_clip;
   logic [NUM_SLOTS-1:0][X_W-1:0]     r_x2_out;
   logic [NUM_SLOTS-1:0]              r_clip_out;
   logic                              r_valid;
   logic                              r_busy;

   logic                w_start;
   logic                w_div_done;
   logic [DIV_BITS-1:0] w_dividend;
   logic [DIV_BITS-1:0] w_divisor;
   logic [DIV_BITS-1:0] w_quotient;
   logic [DEPTH_W-1:0]  w_depth;
   logic [X_W-1:0]      w_x1;
   logic [X_W-1:0]      w_disp;
   logic [X_W-1:0]      w_x2;
   logic                w_sat;
   logic                w_clip;

   assign w_depth   = r_depth[r_idx];
   assign w_x1      = r_x1[r_idx];
   assign w_start   = (r_state == StLoad);
   assign w_divisor = DIV_BITS'(w_depth);

`ifdef PROJECTOR_ROUND_EN
   assign w_dividend = DIV_BITS'(DISPARITY_K) + DIV_BITS'(w_depth >> 1);
`else
   assign w_dividend = DIV_BITS'(DISPARITY_K);
`endif

   seq_divider #(
      .DIV_BITS (DIV_BITS)
   ) u_div (
      .i_clk      (clk_in),
      .i_rst_n    (rst_n_in),
      .i_start    (w_start),
      .i_dividend (w_dividend),
      .i_divisor  (w_divisor),
      .o_done     (w_div_done),
      .o_quotient (w_quotient)
   );

   // Zero depth means "at infinity disparity": saturate regardless of the divider output.
   always_comb begin
      w_sat  = (w_depth == '0) || (w_quotient > DIV_BITS'(X_MAX));
      w_disp = w_sat ? X_MAX : w_quotient[X_W-1:0];
      if (w_disp > w_x1) begin
         w_x2   = '0;
         w_clip = 1'b1;
      end else begin
         w_x2   = w_x1 - w_disp;
         w_clip = w_sat;
      end
   end

   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         r_state     <= StIdle;
         r_idx       <= '0;
         r_last      <= '0;
         r_depth     <= '0;
         r_x1        <= '0;
         r_slot_x2   <= '0;
         r_slot_clip <= '0;
         r_x2_out    <= '0;
         r_clip_out  <= '0;
         r_valid     <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         unique case (r_state)
            StIdle: begin
               if (data_valid_in) begin
                  r_last  <= num_players;
                  r_depth <= depth_in;
                  r_x1    <= x_1_in;
                  r_idx   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= StLoad;
               end
            end
            StLoad:   r_state <= StDivide;
            StDivide: if (w_div_done) r_state <= StWrite;
            StWrite: begin
               r_slot_x2[r_idx]   <= w_x2;
               r_slot_clip[r_idx] <= w_clip;
               r_idx              <= r_idx + 2'd1;
               if (r_idx == r_last) begin
                  // Publish with the slot being written this cycle merged in.
                  for (int i = 0; i < NUM_SLOTS; i++) begin
                     if (2'(i) < r_idx) begin
                        r_x2_out[i]   <= r_slot_x2[i];
                        r_clip_out[i] <= r_slot_clip[i];
                     end else if (2'(i) == r_idx) begin
                        r_x2_out[i]   <= w_x2;
                        r_clip_out[i] <= w_clip;
                     end else begin
                        r_x2_out[i]   <= '0;
                        r_clip_out[i] <= 1'b0;
                     end
                  end
                  r_valid <= 1'b1;
                  r_state <= StDone;
               end else begin
                  r_state <= StLoad;
               end
            end
            StDone: begin
               r_busy  <= 1'b0;
               r_state <= StIdle;
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign busy_out       = r_busy;
   assign data_valid_out = r_valid;
   assign x_2_out        = r_x2_out;
   assign clip_out       = r_clip_out;

endmodule

// File: doc/disparity_projector.md
# disparity_projector

Inverse of the stereo depth path. For each tracked player it takes a target depth and the player's camera-1 column, and computes the column where that player must appear in camera 2 (x_2 = x_1 − K/depth). The result drives the wall-overlay guide markers in the second camera's frame. A single shared sequential divider serves all players in turn, and a one-cycle pulse marks a complete result set.

## Interface
Parameters:
- DISPARITY_K, default 2973: round(FOCAL_LENGTH·BASELINE_DISTANCE·RESOLUTION_WIDTH/SENSOR_WIDTH) for the 1280/0.334646/0.1295276/6 camera pair; 12-bit unsigned.
- DIV_BITS, default 12: dividend width, which is also the divider iteration count.

Ports:
- clk_in, input, 1: system clock.
- rst_n_in, input, 1: reset; synchronous, active-low.
- data_valid_in, input, 1: request strobe; sampled only in IDLE.
- num_players, input, 2: 0..3 encodes 1..4 active players.
- depth_in [3:0], input, 8 each: target depth per player, same units as parallax depth output.
- x_1_in [3:0], input, 11 each: camera-1 column per player.
- busy_out, output, 1: high whenever state ≠ IDLE.
- data_valid_out, output, 1: one-cycle pulse when x_2_out/clip_out update.
- x_2_out [3:0], output, 11 each: projected camera-2 column.
- clip_out [3:0], output, 1 each: disparity saturated, or x_2 clamped at 0.

## Operation
- States: IDLE → LOAD → DIVIDE → WRITE → (LOAD if more players, else DONE) → IDLE.
- IDLE: when data_valid_in is high, capture num_players, depth_in and x_1_in into internal registers and set the player index to 0. No backpressure exists; requests arriving while busy_out is high are dropped.
- LOAD (1 cycle): dividend = DISPARITY_K, divisor = depth[idx], remainder = 0.
- DIVIDE (DIV_BITS cycles): restoring divide, one quotient bit per cycle, MSB first.
- WRITE (1 cycle):
  - disparity = min(quotient, 2047). Saturation sets clip.
  - If depth = 0, disparity = 2047 and clip is set; the divide result is ignored.
  - If disparity > x_1, x_2 = 0 and clip is set. Otherwise x_2 = x_1 − disparity.
  - The result goes into internal slot idx, and idx increments.
- DONE (1 cycle): copy all four slots to x_2_out/clip_out and pulse data_valid_out. Slots at or above the active count read as 0 with clip 0.
- Arithmetic is unsigned throughout. The quotient is 12 bits wide, and it saturates before the 11-bit subtract.

## Timing
- The accepting edge counts as edge 0. Each player costs 14 cycles: LOAD 1 + DIVIDE 12 + WRITE 1.
- data_valid_out is high during the cycle after edge 14·N. That is cycle 15 for one player and cycle 57 for four.
- busy_out rises after edge 0 and falls after the DONE cycle. The earliest next acceptance is at the first edge with busy_out low.
- x_2_out and clip_out change only at the transition into DONE. They hold their values otherwise.
- Reset values: x_2_out all 0, clip_out all 0, data_valid_out 0, busy_out 0, state IDLE.
- Reset asserted mid-run aborts the run with no data_valid_out pulse, and all outputs return to their reset values on the next edge.
- If data_valid_in is high in the same cycle as DONE, it is ignored; it is accepted only when the block is in IDLE.

## Configuration
- PROJECTOR_ROUND_EN defined: LOAD sets dividend = DISPARITY_K + (depth >> 1), giving round-to-nearest. The 12-bit width is sufficient, since the maximum is 3100.
- PROJECTOR_ROUND_EN undefined: dividend = DISPARITY_K, giving floor. Latency is the same in both cases.

## Structure
- Shared package parallax_pkg holds:
  - the player-count encodings ONE_PLAYER..FOUR_PLAYERS;
  - the DISPARITY_K default;
  - the state enum type;
  - the depth, x and y width constants, shared with the parallax modules.
- Sub-module seq_divider: a restoring unsigned divider with start/done handshake, parameterised DIV_BITS, instantiated once. The FSM, index counter and clamp logic stay in disparity_projector.

## Test plan
- One player, depth 100, x_1 640, floor build → x_2 611, clip 0, pulse in cycle 15. With PROJECTOR_ROUND_EN → x_2 610.
- Four players, depths {100, 255, 1, 0}, x_1 {640, 500, 1279, 640}, floor build → x_2 {611, 489, 0, 0}, clip {0, 0, 1, 1}, single pulse in cycle 57. With PROJECTOR_ROUND_EN, slot 1 → 488.
- Two players active with stale nonzero data in slots 2..3 → x_2_out[2..3] = 0 and clip_out[2..3] = 0.
- data_valid_in pulsed again at cycle 5 of a one-player run → ignored; exactly one data_valid_out pulse and no busy extension.
- rst_n_in low at cycle 20 of a four-player run → no pulse, all outputs 0, busy_out 0. A new request after release completes normally.
- Back-to-back requests, the second raised on the first cycle busy_out is low → second accepted; its pulse arrives 14·N cycles later.
